// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and helper functions for the branch predictor table
package bp_pkg;
  localparam int CTR_W_DEF = 2;
  localparam int IDX_W_DEF = 4;
  localparam int CTR_MAX = 64;
  localparam int BP_W = 64;
  function automatic logic [CTR_MAX-1:0] ctr_next(input logic [CTR_MAX-1:0] ctr, input logic taken, input int width);
    logic [CTR_MAX-1:0] top;
    top = (CTR_MAX'(1) << width) - 1'b1;
    return taken ? ((ctr == top) ? ctr : ctr + 1'b1) : ((ctr == '0) ? ctr : ctr - 1'b1);
  endfunction
  // Caller truncates to IDX_W, which also truncates a history wider than the index
  function automatic logic [BP_W-1:0] bp_index(input logic [BP_W-1:0] pc, input logic [BP_W-1:0] ghr);
    return (pc >> 2) ^ ghr;
  endfunction
endpackage

// File: rtl/bp_ghr.sv
// bp_ghr: global history shift register fed with resolved branch outcomes
module bp_ghr #(
  parameter int HIST_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [HIST_W-1:0] ghr_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) ghr_o <= '0;
    else if (shift_i) ghr_o <= HIST_W'({ghr_o, bit_i});
endmodule

// File: rtl/branch_predictor_table.sv
// branch_predictor_table: bimodal/gshare table of saturating counters with lookup statistics
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W = CTR_W_DEF,
  parameter int HIST_W = 0,
  parameter int PC_W = 32,
  parameter int STAT_W = 32,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [PC_W-1:0]   lookup_pc_i,
  output logic              predict_o,
  output logic [IDX_W-1:0]  predict_idx_o,
  input  logic              update_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_taken_i,
  input  logic              update_pred_i,
  output logic              mispredict_o,
  output logic [STAT_W-1:0] lookups_o,
  output logic [STAT_W-1:0] mispredicts_o
);
  localparam int GH_W = (HIST_W > 0) ? HIST_W : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(CTR_MAX'(1) << (CTR_W - 1));
  logic [GH_W-1:0] ghr;
  logic [CTR_W-1:0] ctr [ENTRIES];
  generate
    if (HIST_W > 0) begin : g_hist
      bp_ghr #(.HIST_W(HIST_W)) u_ghr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .shift_i(update_i),
        .bit_i  (update_taken_i),
        .ghr_o  (ghr)
      );
    end else begin : g_bimodal
      assign ghr = '0;
    end
  endgenerate
  assign predict_idx_o = IDX_W'(bp_index(BP_W'(lookup_pc_i), BP_W'(ghr)));
  assign predict_o = lookup_valid_i & ctr[predict_idx_o][CTR_W-1];
  assign mispredict_o = update_i & (update_taken_i != update_pred_i);
  // Flop array so reset initialises every entry asynchronously
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_INIT;
    else if (update_i) ctr[update_idx_i] <= CTR_W'(ctr_next(CTR_MAX'(ctr[update_idx_i]), update_taken_i, CTR_W));
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      lookups_o <= '0;
      mispredicts_o <= '0;
    end else begin
      if (lookup_valid_i && !(&lookups_o)) lookups_o <= lookups_o + 1'b1;
      if (mispredict_o && !(&mispredicts_o)) mispredicts_o <= mispredicts_o + 1'b1;
    end
endmodule

// File: tb/tb_branch_predictor_table.sv
// tb_branch_predictor_table: directed and random checks of bimodal and gshare predictors against a model
module tb_branch_predictor_table;
  logic clk = 0, rst = 1;
  logic lv = 1, upd = 0, ut = 0, up = 0;
  logic [31:0] pc = 32'h20;
  logic [3:0] uidx = 0;
  logic b_pred, g_pred, b_mp, g_mp;
  logic [3:0] b_idx, g_idx;
  logic [31:0] b_look, g_look, b_mis, g_mis;
  int vec = 0, errs = 0;
  int mb[16], mg[16], gh, ml, mm, m0;

  always #5 clk = ~clk;

  branch_predictor_table #(.HIST_W(0)) u_b (
    .clk_i(clk), .rst_i(rst), .lookup_valid_i(lv), .lookup_pc_i(pc),
    .predict_o(b_pred), .predict_idx_o(b_idx), .update_i(upd), .update_idx_i(uidx),
    .update_taken_i(ut), .update_pred_i(up), .mispredict_o(b_mp),
    .lookups_o(b_look), .mispredicts_o(b_mis)
  );
  branch_predictor_table #(.HIST_W(4)) u_g (
    .clk_i(clk), .rst_i(rst), .lookup_valid_i(lv), .lookup_pc_i(pc),
    .predict_o(g_pred), .predict_idx_o(g_idx), .update_i(upd), .update_idx_i(uidx),
    .update_taken_i(ut), .update_pred_i(up), .mispredict_o(g_mp),
    .lookups_o(g_look), .mispredicts_o(g_mis)
  );

  function automatic int m_idx(input int p, input int h);
    return ((p >>> 2) ^ h) & 15;
  endfunction
  function automatic int sat(input int c, input logic t);
    return t ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mb[i] = 2;
        mg[i] = 2;
      end
      gh = 0; ml = 0; mm = 0;
    end else begin
      if (lv) ml++;
      if (upd && ut != up) mm++;
      if (upd) begin
        mb[uidx] = sat(mb[uidx], ut);
        mg[uidx] = sat(mg[uidx], ut);
        gh = ((gh << 1) | int'(ut)) & 15;
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("b_predict", b_pred, lv && mb[m_idx(pc, 0)] >= 2);
      chk("b_idx", b_idx, m_idx(pc, 0));
      chk("g_predict", g_pred, lv && mg[m_idx(pc, gh)] >= 2);
      chk("g_idx", g_idx, m_idx(pc, gh));
      chk("b_mispredict", b_mp, upd && ut != up);
      chk("g_mispredict", g_mp, upd && ut != up);
      chk("b_lookups", b_look, ml);
      chk("g_lookups", g_look, ml);
      chk("b_mispredicts", b_mis, mm);
      chk("g_mispredicts", g_mis, mm);
    end

  task automatic drive(input logic v, input logic [31:0] p, input logic u, input logic [3:0] i, input logic t, input logic pr);
    @(posedge clk); #1;
    lv = v; pc = p; upd = u; uidx = i; ut = t; up = pr;
    @(negedge clk); #1;
  endtask

  initial begin
    #12;
    chk("reset_predict", b_pred, 1);
    chk("reset_g_predict", g_pred, 1);
    chk("reset_lookups", b_look, 0);
    chk("reset_mispredicts", b_mis, 0);
    rst = 0;
    repeat (3) drive(0, 0, 1, 8, 0, 1);
    drive(1, 32'h20, 0, 0, 0, 0);
    chk("sat_low_predict", b_pred, 0);
    drive(1, 32'h20, 1, 8, 1, 0);
    drive(1, 32'h20, 0, 0, 0, 0);
    chk("ctr01_predict", b_pred, 0);
    repeat (2) drive(0, 0, 1, 8, 1, 1);
    drive(1, 32'h20, 0, 0, 0, 0);
    chk("ctr11_predict", b_pred, 1);
    drive(0, 0, 1, 8, 1, 1);
    drive(1, 32'h20, 0, 0, 0, 0);
    chk("sat_high_predict", b_pred, 1);
    drive(0, 0, 1, 3, 1, 1);
    drive(0, 0, 1, 3, 1, 1);
    drive(0, 0, 1, 3, 0, 0);
    drive(0, 0, 1, 3, 1, 1);
    drive(1, 0, 0, 0, 0, 0);
    chk("gshare_idx", g_idx, 13);
    chk("bimodal_idx_pc0", b_idx, 0);
    repeat (3) drive(0, 0, 1, 8, 0, 0);
    drive(1, 32'h60, 0, 0, 0, 0);
    chk("alias_predict", b_pred, 0);
    chk("alias_idx", b_idx, 8);
    drive(0, 0, 1, 8, 1, 1);
    drive(1, 32'h20, 1, 8, 1, 0);
    chk("hazard_predict", b_pred, 0);
    chk("hazard_mispredict", b_mp, 1);
    m0 = mm;
    drive(1, 32'h20, 0, 0, 0, 0);
    chk("hazard_next_predict", b_pred, 1);
    chk("hazard_mis_count", b_mis, m0 + 1);
    repeat (2) drive(0, 0, 1, 8, 0, 0);
    drive(1, 32'h20, 0, 0, 0, 0);
    chk("pre_reset_predict", b_pred, 0);
    rst = 1;
    #1;
    chk("async_lookups", b_look, 0);
    chk("async_mispredicts", b_mis, 0);
    chk("async_predict", b_pred, 1);
    chk("async_g_idx", g_idx, 8);
    #1 rst = 0;
    for (int k = 0; k < 60; k++)
      drive(1'($urandom_range(1)), 32'($urandom_range(255)) << 2, 1'($urandom_range(1)),
            4'($urandom_range(15)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    drive(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
